// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's MEM stage (master) and the
// data-memory responder (slave). Both directions use a valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding load/store at a time,
// RISC-V sized little-endian accesses with sign/zero extension on loads and
// a fixed response latency. Storage is eight byte-lane arrays so a store
// only writes its own lanes and never needs a read-modify-write.
// DEPTH_DW is expected to be a power of two (>= 2).
module dmem_responder #(
  parameter int DEPTH_DW = 256,
  parameter int LATENCY  = 2
) (
  input logic            clk,
  input logic            reset,
  dmem_responder_if.slave bus
);

  localparam int          AW         = $clog2(DEPTH_DW);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_DW) * 64'd8;
  localparam logic [3:0]  CNT_LOAD   = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic        load_ok_reg;

  logic        cap_write_reg;
  logic        cap_unsigned_reg;
  logic [1:0]  cap_size_reg;
  logic [63:0] cap_addr_reg;
  logic [63:0] cap_wdata_reg;

  // Request fields in effect on the edge that enters RESP. With LATENCY=1
  // that edge is the acceptance edge itself, so the live inputs are used.
  logic        sel_write;
  logic [1:0]  sel_size;
  logic [63:0] sel_addr;
  logic [63:0] sel_wdata;
  logic        sel_misaligned;
  logic        sel_err;
  logic        go_resp;
  logic        mem_we;
  logic [7:0]  size_mask;
  logic [7:0]  lane_we;
  logic [63:0] wr_lanes;
  logic [AW-1:0] idx;
  logic [63:0] rd_dword;
  logic [63:0] raw;
  logic [63:0] ext;

  // Select request source and decode access size, alignment and range.
  always_comb begin
    sel_write      = cap_write_reg;
    sel_size       = cap_size_reg;
    sel_addr       = cap_addr_reg;
    sel_wdata      = cap_wdata_reg;
    if (state_reg == IDLE) begin
      sel_write = bus.req_write;
      sel_size  = bus.req_size;
      sel_addr  = bus.req_addr;
      sel_wdata = bus.req_wdata;
    end
    sel_misaligned = 1'b0;
    size_mask      = 8'h01;
    case (sel_size)
      2'd0: begin sel_misaligned = 1'b0;             size_mask = 8'h01; end
      2'd1: begin sel_misaligned = sel_addr[0];      size_mask = 8'h03; end
      2'd2: begin sel_misaligned = |sel_addr[1:0];   size_mask = 8'h0F; end
      default: begin sel_misaligned = |sel_addr[2:0]; size_mask = 8'hFF; end
    endcase
    sel_err  = sel_misaligned || (sel_addr >= ADDR_LIMIT);
    go_resp  = !reset &&
               (((state_reg == IDLE) && bus.req_valid && (LATENCY == 1)) ||
                ((state_reg == WAIT) && (cnt_reg == 4'd0)));
    mem_we   = go_resp && sel_write && !sel_err;
    lane_we  = size_mask << sel_addr[2:0];
    wr_lanes = sel_wdata << {sel_addr[2:0], 3'b000};
    idx      = sel_addr[AW+2:3];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_DW];
      logic [7:0] rd_reg;
      // Byte-lane storage: lane write and registered read on RESP entry.
      always_ff @(posedge clk) begin
        if (go_resp) begin
          if (mem_we && lane_we[gi]) begin
            mem[idx] <= wr_lanes[8*gi +: 8];
          end
          rd_reg <= mem[idx];
        end
      end
      assign rd_dword[8*gi +: 8] = rd_reg;
    end
  endgenerate

  // Align the addressed bytes to bit 0 and extend according to size/sign.
  always_comb begin
    raw = rd_dword >> {cap_addr_reg[2:0], 3'b000};
    ext = raw;
    case (cap_size_reg)
      2'd0:    ext = {{56{!cap_unsigned_reg & raw[7]}},  raw[7:0]};
      2'd1:    ext = {{48{!cap_unsigned_reg & raw[15]}}, raw[15:0]};
      2'd2:    ext = {{32{!cap_unsigned_reg & raw[31]}}, raw[31:0]};
      default: ext = raw;
    endcase
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      req_ready_reg  <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      load_ok_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write_reg    <= bus.req_write;
            cap_unsigned_reg <= bus.req_unsigned;
            cap_size_reg     <= bus.req_size;
            cap_addr_reg     <= bus.req_addr;
            cap_wdata_reg    <= bus.req_wdata;
            req_ready_reg    <= 1'b0;
            if (LATENCY == 1) begin
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= sel_err;
              load_ok_reg    <= !sel_write && !sel_err;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg      <= RESP;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= sel_err;
            load_ok_reg    <= !sel_write && !sel_err;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_reg      <= IDLE;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            load_ok_reg    <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_err   = resp_err_reg;
  assign bus.resp_rdata = load_ok_reg ? ext : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 4) share request
// stimulus; a vector table plus hand-written back-pressure and reset cases.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset2, reset4, sel;
  logic        req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;

  dmem_responder_if bus2();
  dmem_responder_if bus4();

  assign bus2.req_valid    = req_valid & !sel;
  assign bus4.req_valid    = req_valid & sel;
  assign bus2.req_write    = req_write;
  assign bus4.req_write    = req_write;
  assign bus2.req_size     = req_size;
  assign bus4.req_size     = req_size;
  assign bus2.req_unsigned = req_unsigned;
  assign bus4.req_unsigned = req_unsigned;
  assign bus2.req_addr     = req_addr;
  assign bus4.req_addr     = req_addr;
  assign bus2.req_wdata    = req_wdata;
  assign bus4.req_wdata    = req_wdata;
  assign bus2.resp_ready   = resp_ready;
  assign bus4.resp_ready   = resp_ready;

  dmem_responder #(.DEPTH_DW(DEPTH), .LATENCY(2)) u_dut2 (.clk(clk), .reset(reset2), .bus(bus2));
  dmem_responder #(.DEPTH_DW(DEPTH), .LATENCY(4)) u_dut4 (.clk(clk), .reset(reset4), .bus(bus4));

  logic        o_req_ready, o_resp_valid, o_resp_err;
  logic [63:0] o_resp_rdata;
  always_comb begin
    o_req_ready  = sel ? bus4.req_ready  : bus2.req_ready;
    o_resp_valid = sel ? bus4.resp_valid : bus2.resp_valid;
    o_resp_err   = sel ? bus4.resp_err   : bus2.resp_err;
    o_resp_rdata = sel ? bus4.resp_rdata : bus2.resp_rdata;
  end

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[19];

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one request, wait for its response and compare against the scoreboard.
  task automatic txn(input logic wr, input logic [1:0] size, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp_rdata, input logic exp_err,
                     input int lat, input string name);
    exp_t e;
    int k;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    sb_q.push_back(e);
    check64({name, "_req_ready"}, 64'(o_req_ready), 64'd1);
    req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!o_resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check64({name, "_latency"}, 64'(k), 64'(lat));
    e = sb_q.pop_front();
    if (o_resp_valid) begin
      check64({name, "_rdata"}, o_resp_rdata, e.rdata);
      check64({name, "_err"}, 64'(o_resp_err), 64'(e.err));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no resp_valid expected response", name);
    end
    $display("txn %s wr=%0d size=%0d addr=%h rdata=%h err=%0d latency=%0d",
             name, wr, size, addr, o_resp_rdata, o_resp_err, k);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    logic seen;
    exp_t e;

    vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h10,  64'h1122334455667788, 64'h0, 1'b0};
    vecs[1]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 64'h13,  64'hFFFFFFFFFFFFFF80, 64'h0, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334480667788, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 64'h13,  64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 64'h13,  64'h0, 64'h80, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h12,  64'h0, 64'hFFFFFFFFFFFF8066, 1'b0};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 64'h12,  64'hDEADBEEF, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0, 64'h1122334480667788, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 1'b0, 64'h800, 64'h0, 64'h0, 1'b1};
    vecs[10] = '{1'b0, 2'd2, 1'b1, 64'h10,  64'h0, 64'h0000000080667788, 1'b0};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 64'h10,  64'h0, 64'hFFFFFFFF80667788, 1'b0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 64'h16,  64'h123456789ABCABCD, 64'h0, 1'b0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 64'h14,  64'h0, 64'hFFFFFFFFABCD3344, 1'b0};
    vecs[14] = '{1'b0, 2'd1, 1'b1, 64'h16,  64'h0, 64'h000000000000ABCD, 1'b0};
    vecs[15] = '{1'b0, 2'd1, 1'b1, 64'h11,  64'h0, 64'h0, 1'b1};
    vecs[16] = '{1'b1, 2'd0, 1'b0, 64'h7FF, 64'h5A, 64'h0, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 64'h7FF, 64'h0, 64'h5A, 1'b0};
    vecs[18] = '{1'b1, 2'd2, 1'b0, 64'h804, 64'h12345678, 64'h0, 1'b1};

    sel = 1'b0; reset2 = 1'b1; reset4 = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b1;

    // Reset for two cycles, then check idle outputs of both instances.
    repeat (2) @(posedge clk);
    #1;
    reset2 = 1'b0; reset4 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check64($sformatf("reset%0d_req_ready", s), 64'(o_req_ready), 64'd1);
      check64($sformatf("reset%0d_resp_valid", s), 64'(o_resp_valid), 64'd0);
      check64($sformatf("reset%0d_resp_rdata", s), o_resp_rdata, 64'd0);
      check64($sformatf("reset%0d_resp_err", s), 64'(o_resp_err), 64'd0);
    end
    sel = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors on the LATENCY=2 instance.
    for (int i = 0; i < 19; i++) begin
      txn(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err, 2, $sformatf("vec%0d", i));
    end

    // Back-pressure: response held for 5 cycles with resp_ready low.
    resp_ready = 1'b0;
    e.rdata = 64'hABCD334480667788;
    e.err   = 1'b0;
    sb_q.push_back(e);
    check64("bp_req_ready", 64'(o_req_ready), 64'd1);
    req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!o_resp_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check64("bp_latency", 64'(k), 64'd2);
    e = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      check64($sformatf("bp_valid_c%0d", c), 64'(o_resp_valid), 64'd1);
      check64($sformatf("bp_rdata_c%0d", c), o_resp_rdata, e.rdata);
      check64($sformatf("bp_req_ready_c%0d", c), 64'(o_req_ready), 64'd0);
      @(posedge clk); #1;
    end
    $display("txn bp_load addr=%h rdata=%h held=5", 64'h10, o_resp_rdata);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check64("bp_release_valid", 64'(o_resp_valid), 64'd0);
    check64("bp_release_ready", 64'(o_req_ready), 64'd1);

    // Reset mid-WAIT on the LATENCY=4 instance.
    sel = 1'b1;
    #1;
    txn(1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF, 64'h0, 1'b0, 4, "l4_prior_store");
    check64("mw_req_ready", 64'(o_req_ready), 64'd1);
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h20; req_wdata = 64'hAA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset4 = 1'b1;
    @(posedge clk); #1;
    reset4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (o_resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check64("mw_no_response", 64'(seen), 64'd0);
    check64("mw_idle_ready", 64'(o_req_ready), 64'd1);
    $display("txn mw_aborted_store addr=%h wdata=%h", 64'h20, 64'hAA);
    txn(1'b0, 2'd3, 1'b0, 64'h20, 64'h0, 64'h0123456789ABCDEF, 1'b0, 4, "l4_after_abort_d");
    txn(1'b0, 2'd0, 1'b0, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFFEF, 1'b0, 4, "l4_after_abort_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the pipelined RISC-V core's MEM stage. It accepts one request at a time over a valid/ready handshake and performs RISC-V sized accesses: byte, half, word and doubleword, little-endian, with sign or zero extension on loads. After a configurable latency it returns a response, also over a valid/ready handshake. The core's hazard logic stalls on `req_ready`/`resp_valid`.

## Interface
- `DEPTH_DW`, 256: storage size in 64-bit doublewords; valid byte addresses are 0 .. DEPTH_DW*8-1.
- `LATENCY`, 2: cycles from the acceptance cycle to the first `resp_valid` cycle; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 doubleword (funct3[1:0]).
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0 (funct3[2]); ignored for stores.
- `req_addr`  in  64  byte address.
- `req_wdata`  in  64  store data; only the low 8·2^size bits are used.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  core takes the response.
- `resp_rdata`  out  64  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - Acceptance happens on an edge with `req_valid`=1. At that edge all `req_*` inputs are captured into internal registers.
  - Next state is RESP if LATENCY=1, otherwise WAIT with the down-counter loaded to LATENCY-2.
- **WAIT**
  - `req_ready`=0 and `resp_valid`=0.
  - The counter decrements each edge. At the edge where it reads 0, go to RESP.
- **Memory action** on the edge that enters RESP:
  - error = (addr mod 2^size ≠ 0) or (addr ≥ DEPTH_DW*8).
  - Error: no array write; `resp_err`=1; `resp_rdata`=0.
  - Store with no error: write only the addressed bytes of doubleword addr[63:3], using byte lanes addr[2:0]; all other bytes are unchanged. `resp_rdata`=0.
  - Load with no error: extract the addressed bytes, then sign- or zero-extend to 64 bits into `resp_rdata`.
- **RESP**
  - `resp_valid`=1.
  - `resp_rdata` and `resp_err` are registered and stable until the handshake.
  - When `resp_ready`=1 at an edge, go to IDLE.
  - `req_ready` stays 0 until back in IDLE, so there is no same-edge handoff.
- Only one request is ever outstanding. Inputs outside the acceptance edge are ignored.
- Storage array contents are not affected by `reset`. Content is undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `req_ready`=1 in the first cycle after the reset edge, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Reset mid-operation (WAIT or RESP): the request is aborted and the FSM returns to IDLE.
  - A store caught in WAIT is never committed.
  - A store already committed on entry to RESP remains in memory.
- Latency: acceptance in cycle N gives `resp_valid`=1 in cycle N+LATENCY.
- Minimum spacing between acceptances is LATENCY+1 cycles, with `resp_ready` held at 1.
- Back-pressure: `resp_valid` is held indefinitely while `resp_ready`=0, and outputs do not change.
- Stores are visible to any later load; a load always sees the most recent committed store.
- All outputs are registered or decoded from the state only; there is no combinational path from any input to any output.

## Test plan
- **Reset and idle:** assert `reset` for 2 cycles, then release → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Doubleword round trip:** store size 11, addr 0x10, data 0x1122334455667788, then load the same address, with LATENCY=2 → each `resp_valid` appears exactly 2 cycles after acceptance; load returns 0x1122334455667788, `resp_err`=0.
- **Byte and half extension:**
  - Store byte 0x80 at addr 0x13 → the doubleword at 0x10 becomes 0x1122334480667788.
  - Load byte signed at 0x13 → 0xFFFFFFFFFFFFFF80.
  - Load byte unsigned at 0x13 → 0x80.
  - Load half signed at 0x12 → 0xFFFFFFFFFFFF8066.
- **Errors:**
  - Word store at 0x12 (misaligned) → `resp_err`=1, `resp_rdata`=0, and the doubleword at 0x10 is unchanged.
  - Load at addr DEPTH_DW*8 → `resp_err`=1.
- **Back-pressure:** hold `resp_ready`=0 for 5 cycles during a load response → `resp_valid` and `resp_rdata` are stable for all 5 cycles; `req_ready`=0 throughout; IDLE is reached one edge after `resp_ready`=1.
- **Reset mid-WAIT:** with LATENCY=4, accept a store of 0xAA at 0x20, then assert `reset` 1 cycle later → no response is produced, and a following load at 0x20 returns the prior content.
